// File: rtl/ntt_seq_if.sv
// Bus bundle between the ntt sequencer and its source RAM, destination RAM and ntt core.
// The master side is the sequencer; the slave side is the RAMs plus the core.
interface ntt_seq_if #(
  parameter int DEPTH = 8
);
  logic             src_rd_en;
  logic [DEPTH-2:0] src_addr;
  logic [31:0]      src_rdata;

  logic             dst_wr_en;
  logic [DEPTH-2:0] dst_addr;
  logic [31:0]      dst_wdata;

  logic             ntt_set;
  logic             ntt_readin;
  logic [15:0]      ntt_din_1;
  logic [15:0]      ntt_din_2;
  logic [DEPTH-1:0] ntt_in_index;
  logic             ntt_cal_en;
  logic             ntt_done;
  logic             ntt_readout;
  logic [15:0]      ntt_dout_1;
  logic [15:0]      ntt_dout_2;
  logic [DEPTH-1:0] ntt_out_index;

  // Handshake: strobes are single-cycle qualifiers with no back-pressure; src_rdata is
  // valid the cycle after src_rd_en, core outputs are valid RD_LAT cycles after ntt_readout.
  modport master (
    output src_rd_en, src_addr, dst_wr_en, dst_addr, dst_wdata,
           ntt_set, ntt_readin, ntt_din_1, ntt_din_2, ntt_in_index, ntt_cal_en, ntt_readout,
    input  src_rdata, ntt_done, ntt_dout_1, ntt_dout_2, ntt_out_index
  );

  modport slave (
    input  src_rd_en, src_addr, dst_wr_en, dst_addr, dst_wdata,
           ntt_set, ntt_readin, ntt_din_1, ntt_din_2, ntt_in_index, ntt_cal_en, ntt_readout,
    output src_rdata, ntt_done, ntt_dout_1, ntt_dout_2, ntt_out_index
  );
endinterface

// File: rtl/ntt_seq_ctrl.sv
// Sequencer around the ntt core: load one polynomial from source RAM, compute, drain to
// destination RAM, pulse done. Optional CALC watchdog enabled by macro NTT_SEQ_TIMEOUT_EN.
module ntt_seq_ctrl #(
  parameter int DEPTH   = 8,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  dbg_state,
  ntt_seq_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_LOAD, S_CALC, S_DRAIN, S_FLUSH, S_FIN
  } state_t;

  localparam int               NPAIR  = 2 ** (DEPTH - 1);
  localparam logic [DEPTH-2:0] K_LAST = '1;
  localparam logic [DEPTH-1:0] D_LAST = DEPTH'(NPAIR - 1);
  localparam logic [DEPTH-1:0] F_LAST = DEPTH'(RD_LAT - 1);

  state_t            state;
  logic [DEPTH-1:0]  cnt;
  logic [RD_LAT-1:0] rd_pipe;

`ifdef NTT_SEQ_TIMEOUT_EN
  localparam int          TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt;
`else
  assign err = 1'b0;
`endif

  assign dbg_state = state;

  // The source RAM output is already registered, so din follows it directly while readin
  // marks the beat; gating keeps din at 0 whenever no beat is presented.
  assign bus.ntt_din_1 = bus.ntt_readin ? bus.src_rdata[31:16] : 16'h0;
  assign bus.ntt_din_2 = bus.ntt_readin ? bus.src_rdata[15:0]  : 16'h0;

  logic unused_idx_lsb;
  assign unused_idx_lsb = bus.ntt_out_index[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      cnt              <= '0;
      rd_pipe          <= '0;
      bus.src_rd_en    <= 1'b0;
      bus.src_addr     <= '0;
      bus.dst_wr_en    <= 1'b0;
      bus.dst_addr     <= '0;
      bus.dst_wdata    <= '0;
      bus.ntt_set      <= 1'b0;
      bus.ntt_readin   <= 1'b0;
      bus.ntt_in_index <= '0;
      bus.ntt_cal_en   <= 1'b0;
      bus.ntt_readout  <= 1'b0;
`ifdef NTT_SEQ_TIMEOUT_EN
      err              <= 1'b0;
      tcnt             <= '0;
`endif
    end else begin
      bus.ntt_set <= 1'b0;
      done        <= 1'b0;

      // Readout beats travel RD_LAT deep so the write lines up with valid core outputs.
      for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      rd_pipe[0]    <= bus.ntt_readout;
      bus.dst_wr_en <= rd_pipe[RD_LAT-1];
      if (rd_pipe[RD_LAT-1]) begin
        bus.dst_addr  <= bus.ntt_out_index[DEPTH-1:1];
        bus.dst_wdata <= {bus.ntt_dout_1, bus.ntt_dout_2};
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_SET;
            busy        <= 1'b1;
            bus.ntt_set <= 1'b1;
            cnt         <= '0;
`ifdef NTT_SEQ_TIMEOUT_EN
            err         <= 1'b0;
`endif
          end
        end
        S_SET: begin
          state         <= S_LOAD;
          bus.src_rd_en <= 1'b1;
          bus.src_addr  <= '0;
        end
        S_LOAD: begin
          // src_rd_en doubles as the extra counter bit: low means the final beat is out.
          if (bus.src_rd_en) begin
            bus.ntt_readin   <= 1'b1;
            bus.ntt_in_index <= {bus.src_addr, 1'b0};
            if (bus.src_addr == K_LAST) bus.src_rd_en <= 1'b0;
            else                        bus.src_addr  <= bus.src_addr + 1'b1;
          end else begin
            bus.ntt_readin <= 1'b0;
            bus.ntt_cal_en <= 1'b1;
            state          <= S_CALC;
`ifdef NTT_SEQ_TIMEOUT_EN
            tcnt           <= '0;
`endif
          end
        end
        S_CALC: begin
          if (bus.ntt_done) begin
            bus.ntt_cal_en  <= 1'b0;
            bus.ntt_readout <= 1'b1;
            cnt             <= '0;
            state           <= S_DRAIN;
          end
`ifdef NTT_SEQ_TIMEOUT_EN
          else if (tcnt == T_LAST) begin
            bus.ntt_cal_en <= 1'b0;
            err            <= 1'b1;
            done           <= 1'b1;
            state          <= S_FIN;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        S_DRAIN: begin
          if (cnt == D_LAST) begin
            bus.ntt_readout <= 1'b0;
            cnt             <= '0;
            state           <= S_FLUSH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FLUSH: begin
          if (cnt == F_LAST) begin
            done  <= 1'b1;
            state <= S_FIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Bench for ntt_seq_ctrl: RAM and core models around the sequencer, reference results
// computed as coef ^ key per index; RD_LAT=3, TIMEOUT=16.
module tb_ntt_seq_ctrl;
  localparam int DEPTH   = 8;
  localparam int NPAIR   = 128;
  localparam int RD_LAT  = 3;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, err;
  logic [2:0] dbg_state;

  ntt_seq_if #(.DEPTH(DEPTH)) bus ();

  ntt_seq_ctrl #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state), .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- models: source RAM and ntt core ----------------
  logic [31:0] src_mem [NPAIR];
  logic [15:0] core_mem [2*NPAIR];
  logic [15:0] key;
  int          done_after;
  bit          never_done;
  int          cal_cnt;
  logic [6:0]  ro_ptr;
  logic        dl_v   [RD_LAT];
  logic [7:0]  dl_idx [RD_LAT];

  function automatic logic [6:0] rev7(input logic [6:0] x);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = x[6-i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.src_rd_en) bus.src_rdata <= src_mem[bus.src_addr];
    else               bus.src_rdata <= $urandom;
  end

  always @(posedge clk) begin
    if (reset) begin
      cal_cnt <= 0;
      ro_ptr  <= '0;
      for (int i = 0; i < RD_LAT; i++) dl_v[i] <= 1'b0;
    end else begin
      if (bus.ntt_set) begin
        cal_cnt <= 0;
        ro_ptr  <= '0;
      end
      if (bus.ntt_readin) begin
        core_mem[bus.ntt_in_index]     <= bus.ntt_din_2;
        core_mem[bus.ntt_in_index + 1] <= bus.ntt_din_1;
      end
      if (bus.ntt_cal_en) cal_cnt <= cal_cnt + 1;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        dl_v[i]   <= dl_v[i-1];
        dl_idx[i] <= dl_idx[i-1];
      end
      dl_v[0]   <= bus.ntt_readout;
      dl_idx[0] <= {rev7(ro_ptr), 1'b0};
      if (bus.ntt_readout) ro_ptr <= ro_ptr + 1'b1;
    end
  end

  assign bus.ntt_done = bus.ntt_cal_en && !never_done && (cal_cnt + 1 >= done_after);

  always_comb begin
    if (dl_v[RD_LAT-1]) begin
      bus.ntt_out_index = dl_idx[RD_LAT-1];
      bus.ntt_dout_1    = core_mem[dl_idx[RD_LAT-1] + 1] ^ key;
      bus.ntt_dout_2    = core_mem[dl_idx[RD_LAT-1]] ^ key;
    end else begin
      bus.ntt_out_index = 8'hff;
      bus.ntt_dout_1    = 16'hdead;
      bus.ntt_dout_2    = 16'hbeef;
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  int n_rd, n_readin, n_wr, n_done, n_set, n_ro, cal_cycles, excl_err;
  int first_rd_cyc, first_in_cyc, first_ro_cyc, last_cal_cyc, last_ro_cyc, last_wr_cyc, done_cyc;
  logic [7:0]  in_idx_q [$];
  logic [31:0] in_din_q [$];
  logic [31:0] dst_mem [NPAIR];
  logic [31:0] exp_q [$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset) begin
      if (bus.src_rd_en) begin n_rd++; if (first_rd_cyc < 0) first_rd_cyc = cyc; end
      if (bus.ntt_readin) begin
        n_readin++;
        if (first_in_cyc < 0) first_in_cyc = cyc;
        in_idx_q.push_back(bus.ntt_in_index);
        in_din_q.push_back({bus.ntt_din_1, bus.ntt_din_2});
      end
      if (bus.ntt_cal_en) begin cal_cycles++; last_cal_cyc = cyc; end
      if (bus.ntt_readout) begin n_ro++; last_ro_cyc = cyc; if (first_ro_cyc < 0) first_ro_cyc = cyc; end
      if (bus.dst_wr_en) begin n_wr++; dst_mem[bus.dst_addr] = bus.dst_wdata; last_wr_cyc = cyc; end
      if (done) begin n_done++; done_cyc = cyc; end
      if (bus.ntt_set) n_set++;
      if (int'(bus.ntt_readin) + int'(bus.ntt_cal_en) + int'(bus.ntt_readout) > 1) excl_err++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    n_rd = 0; n_readin = 0; n_wr = 0; n_done = 0; n_set = 0; n_ro = 0; cal_cycles = 0; excl_err = 0;
    first_rd_cyc = -1; first_in_cyc = -1; first_ro_cyc = -1;
    last_cal_cyc = -1; last_ro_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
    in_idx_q.delete(); in_din_q.delete(); exp_q.delete();
    for (int i = 0; i < NPAIR; i++) dst_mem[i] = 'x;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic load_ramp();
    for (int k = 0; k < NPAIR; k++) src_mem[k] = {16'(2*k + 1), 16'(2*k)};
    key = 16'($urandom);
  endtask

  task automatic load_random();
    for (int k = 0; k < NPAIR; k++) src_mem[k] = $urandom;
    key = 16'($urandom);
  endtask

  task automatic build_expected();
    for (int a = 0; a < NPAIR; a++) exp_q.push_back(src_mem[a] ^ {key, key});
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if ({busy, done, err, bus.src_rd_en, bus.dst_wr_en, bus.ntt_set, bus.ntt_readin, bus.ntt_cal_en, bus.ntt_readout} !== 9'b0) begin
      miscompares++; $display("FAIL reset_ctl: got %b want 0", {busy, done, err, bus.src_rd_en, bus.dst_wr_en, bus.ntt_set, bus.ntt_readin, bus.ntt_cal_en, bus.ntt_readout}); end
    vectors++; if ({bus.src_addr, bus.dst_addr, bus.dst_wdata, bus.ntt_din_1, bus.ntt_din_2, bus.ntt_in_index} !== '0) begin
      miscompares++; $display("FAIL reset_data: got %h want 0", {bus.src_addr, bus.dst_addr, bus.dst_wdata, bus.ntt_din_1, bus.ntt_din_2, bus.ntt_in_index}); end
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_ramp();
    bit ok;
    load_ramp(); done_after = 50; never_done = 1'b0;
    clear_counts(); build_expected();
    pulse_start();
    wait_done(2000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL ramp_done_seen: got 0 want 1"); end
    @(negedge clk);
    vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL ramp_after: got busy,done=%b want 00", {busy, done}); end
    vectors++; if (n_set !== 1) begin miscompares++; $display("FAIL ramp_set: got %0d want 1", n_set); end
    vectors++; if (n_rd !== NPAIR) begin miscompares++; $display("FAIL ramp_src_reads: got %0d want %0d", n_rd, NPAIR); end
    vectors++; if (n_readin !== NPAIR) begin miscompares++; $display("FAIL ramp_readin: got %0d want %0d", n_readin, NPAIR); end
    vectors++; if (first_in_cyc !== first_rd_cyc + 1) begin miscompares++; $display("FAIL ramp_readin_lag: got %0d want %0d", first_in_cyc, first_rd_cyc + 1); end
    for (int k = 0; k < NPAIR; k++) begin
      logic [7:0]  gi;
      logic [31:0] gd;
      gi = (in_idx_q.size() > 0) ? in_idx_q.pop_front() : 8'hxx;
      gd = (in_din_q.size() > 0) ? in_din_q.pop_front() : 32'hxxxxxxxx;
      vectors++; if (gi !== 8'(2*k)) begin miscompares++; $display("FAIL ramp_in_index[%0d]: got %0d want %0d", k, gi, 2*k); end
      vectors++; if (gd !== {16'(2*k + 1), 16'(2*k)}) begin miscompares++; $display("FAIL ramp_din[%0d]: got %h want %h", k, gd, {16'(2*k + 1), 16'(2*k)}); end
    end
    vectors++; if (cal_cycles !== 50) begin miscompares++; $display("FAIL ramp_cal_cycles: got %0d want 50", cal_cycles); end
    vectors++; if (n_ro !== NPAIR) begin miscompares++; $display("FAIL ramp_readout: got %0d want %0d", n_ro, NPAIR); end
    vectors++; if (n_wr !== NPAIR) begin miscompares++; $display("FAIL ramp_dst_writes: got %0d want %0d", n_wr, NPAIR); end
    vectors++; if (last_wr_cyc !== last_ro_cyc + 1 + RD_LAT) begin miscompares++; $display("FAIL ramp_last_write: got %0d want %0d", last_wr_cyc, last_ro_cyc + 1 + RD_LAT); end
    vectors++; if (done_cyc < last_wr_cyc) begin miscompares++; $display("FAIL ramp_done_order: got %0d want >= %0d", done_cyc, last_wr_cyc); end
    vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL ramp_done_count: got %0d want 1", n_done); end
    vectors++; if (excl_err !== 0) begin miscompares++; $display("FAIL ramp_exclusive: got %0d want 0", excl_err); end
    for (int a = 0; a < NPAIR; a++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      vectors++; if (dst_mem[a] !== e) begin miscompares++; $display("FAIL ramp_dst[%0d]: got %h want %h", a, dst_mem[a], e); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int r = 0; r < 3; r++) begin
      load_random(); done_after = $urandom_range(1, 80); never_done = 1'b0;
      clear_counts(); build_expected();
      pulse_start();
      wait_done(2000, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_done_seen[%0d]: got 0 want 1", r); end
      vectors++; if (cal_cycles !== done_after) begin miscompares++; $display("FAIL b2b_cal_cycles[%0d]: got %0d want %0d", r, cal_cycles, done_after); end
      vectors++; if (n_wr !== NPAIR) begin miscompares++; $display("FAIL b2b_dst_writes[%0d]: got %0d want %0d", r, n_wr, NPAIR); end
      vectors++; if (excl_err !== 0) begin miscompares++; $display("FAIL b2b_exclusive[%0d]: got %0d want 0", r, excl_err); end
      for (int a = 0; a < NPAIR; a++) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        vectors++; if (dst_mem[a] !== e) begin miscompares++; $display("FAIL b2b_dst[%0d][%0d]: got %h want %h", r, a, dst_mem[a], e); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    bit ok;
    bit seen;
    load_ramp(); done_after = 20; never_done = 1'b0;
    clear_counts();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ntt_readin) begin seen = 1'b1; break; end
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL ign_load_reached: got 0 want 1"); end
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(2000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL ign_done_seen: got 0 want 1"); end
    start = 1'b1; @(negedge clk); start = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ign_busy_after_fin: got %b want 0", busy); end
    repeat (20) @(negedge clk);
    vectors++; if (n_set !== 1) begin miscompares++; $display("FAIL ign_runs: got %0d want 1", n_set); end
    vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL ign_done_count: got %0d want 1", n_done); end
    vectors++; if (n_wr !== NPAIR) begin miscompares++; $display("FAIL ign_dst_writes: got %0d want %0d", n_wr, NPAIR); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ign_idle: got %b want 0", busy); end
  endtask

  task automatic test_done_first();
    bit ok;
    load_random(); done_after = 1; never_done = 1'b0;
    clear_counts();
    pulse_start();
    wait_done(2000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL first_done_seen: got 0 want 1"); end
    vectors++; if (cal_cycles !== 1) begin miscompares++; $display("FAIL first_cal_cycles: got %0d want 1", cal_cycles); end
    vectors++; if (first_ro_cyc !== last_cal_cyc + 1) begin miscompares++; $display("FAIL first_drain_follows: got %0d want %0d", first_ro_cyc, last_cal_cyc + 1); end
    vectors++; if (n_wr !== NPAIR) begin miscompares++; $display("FAIL first_dst_writes: got %0d want %0d", n_wr, NPAIR); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    bit seen;
    load_random(); done_after = 10; never_done = 1'b0;
    clear_counts();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (n_ro >= 40) begin seen = 1'b1; break; end
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL rst_drain_reached: got 0 want 1"); end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++; if ({busy, done, err, bus.src_rd_en, bus.dst_wr_en, bus.ntt_set, bus.ntt_readin, bus.ntt_cal_en, bus.ntt_readout} !== 9'b0) begin
      miscompares++; $display("FAIL rst_mid_ctl: got %b want 0", {busy, done, err, bus.src_rd_en, bus.dst_wr_en, bus.ntt_set, bus.ntt_readin, bus.ntt_cal_en, bus.ntt_readout}); end
    vectors++; if ({bus.dst_addr, bus.dst_wdata, bus.ntt_in_index} !== '0) begin
      miscompares++; $display("FAIL rst_mid_data: got %h want 0", {bus.dst_addr, bus.dst_wdata, bus.ntt_in_index}); end
    @(negedge clk); reset = 1'b0;
    repeat (5) @(negedge clk);
    load_random(); done_after = $urandom_range(5, 60);
    clear_counts(); build_expected();
    pulse_start();
    wait_done(2000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rst_rerun_done: got 0 want 1"); end
    vectors++; if (n_wr !== NPAIR) begin miscompares++; $display("FAIL rst_rerun_writes: got %0d want %0d", n_wr, NPAIR); end
    for (int a = 0; a < NPAIR; a++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      vectors++; if (dst_mem[a] !== e) begin miscompares++; $display("FAIL rst_rerun_dst[%0d]: got %h want %h", a, dst_mem[a], e); end
    end
    @(negedge clk);
  endtask

`ifdef NTT_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    load_random(); never_done = 1'b1; done_after = 1;
    clear_counts();
    pulse_start();
    wait_done(2000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL to_done_seen: got 0 want 1"); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL to_err: got %b want 1", err); end
    vectors++; if (cal_cycles !== TIMEOUT) begin miscompares++; $display("FAIL to_cal_cycles: got %0d want %0d", cal_cycles, TIMEOUT); end
    vectors++; if ({n_ro, n_wr} !== {32'd0, 32'd0}) begin miscompares++; $display("FAIL to_no_drain: got ro=%0d wr=%0d want 0", n_ro, n_wr); end
    repeat (5) @(negedge clk);
    vectors++; if ({busy, err} !== 2'b01) begin miscompares++; $display("FAIL to_sticky: got busy,err=%b want 01", {busy, err}); end
    vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL to_done_count: got %0d want 1", n_done); end
    never_done = 1'b0; done_after = 5;
    clear_counts();
    pulse_start();
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL to_err_clear: got %b want 0", err); end
    wait_done(2000, ok);
    vectors++; if (!ok || n_wr !== NPAIR) begin miscompares++; $display("FAIL to_rerun: got done=%b wr=%0d want 1/%0d", ok, n_wr, NPAIR); end
    @(negedge clk);
  endtask
`else
  task automatic test_no_timeout();
    load_random(); never_done = 1'b1;
    clear_counts();
    pulse_start();
    repeat (600) @(negedge clk);
    vectors++; if ({busy, bus.ntt_cal_en, err} !== 3'b110) begin miscompares++; $display("FAIL wait_calc: got busy,cal_en,err=%b want 110", {busy, bus.ntt_cal_en, err}); end
    vectors++; if ({n_wr, n_done} !== {32'd0, 32'd0}) begin miscompares++; $display("FAIL wait_nothing_out: got wr=%0d done=%0d want 0", n_wr, n_done); end
    reset = 1'b1; @(negedge clk); reset = 1'b0; never_done = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; key = '0; never_done = 1'b0; done_after = 50;
    for (int k = 0; k < NPAIR; k++) src_mem[k] = '0;
    for (int i = 0; i < 2*NPAIR; i++) core_mem[i] = '0;
    clear_counts();
    test_reset();
    test_ramp();
    test_back_to_back();
    test_ignored_start();
    test_done_first();
    test_reset_mid_drain();
`ifdef NTT_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: got no finish want finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
